// File: rtl/acc32_seq.sv
// acc32_seq: streaming 32-bit accumulator around one cla32 adder.
// Optional unsigned saturation is enabled by defining ACC32_SAT_EN.

module cla32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ci_i,
  output logic [31:0] s_o,
  output logic        co_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  // 4-bit lookahead groups, group carries chained across the word
  always_comb begin
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 8; k++) begin
      gp[k] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
        gp[k] = gp[k] & p[4*k+j];
      end
    end
    gc[0] = ci_i;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    s_o  = p ^ c;
    co_o = gc[8];
  end

endmodule

module acc32_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_co,
  output logic        out_ovf,
  output logic [7:0]  out_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        co_q;
  logic        co_d;
  logic        ovf_q;
  logic        ovf_d;

  logic        accept;
  logic        idle;
  logic [31:0] add_a;
  logic [31:0] sum;
  logic        co;
  logic        ovf_raw;
  logic        co_base;
  logic        ovf_base;

  assign idle   = (state_q == IDLE);
  assign accept = in_valid & in_ready;
  assign add_a  = idle ? 32'd0 : acc_q;

  cla32 u_cla (
    .a_i  (add_a),
    .b_i  (in_data),
    .ci_i (1'b0),
    .s_o  (sum),
    .co_o (co)
  );

  // Signed overflow judged on the raw adder result in both builds
  assign ovf_raw  = (add_a[31] == in_data[31]) &
                    (sum[31] != add_a[31]);
  assign co_base  = idle ? 1'b0 : co_q;
  assign ovf_base = idle ? 1'b0 : ovf_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            state_d = in_last ? DONE : ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE, ACC: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next-state: accumulate, count, sticky flags
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    co_d  = co_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      co_d  = 1'b0;
      ovf_d = 1'b0;
    end else if (accept) begin
`ifdef ACC32_SAT_EN
      acc_d = co ? 32'hFFFF_FFFF : sum;
`else
      acc_d = sum;
`endif
      co_d  = co_base | co;
      ovf_d = ovf_base | ovf_raw;
      cnt_d = idle ? 8'd1 :
              (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end else if ((state_q == DONE) && out_ready) begin
      acc_d = '0;
      cnt_d = '0;
      co_d  = 1'b0;
      ovf_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_sum = acc_q;
  assign out_cnt = cnt_q;
  assign out_co  = co_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_acc32_seq.sv
// Bench for acc32_seq: reference model feeds a result queue,
// results are popped and compared as the DUT presents them.

module tb_acc32_seq;

  typedef struct packed {
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        co;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_co;
  logic        out_ovf;
  logic [7:0]  out_cnt;

  int vectors;
  int miscompares;

  res_t        sb_q[$];
  logic [31:0] m_acc;
  logic [7:0]  m_cnt;
  logic        m_co;
  logic        m_ovf;

  acc32_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic res_t actual();
    actual = '{sum: out_sum, cnt: out_cnt, co: out_co, ovf: out_ovf};
  endfunction

  task automatic model_zero();
    m_acc = '0;
    m_cnt = '0;
    m_co  = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_add(input logic [31:0] d);
    logic [32:0] t;
    t = {1'b0, m_acc} + {1'b0, d};
    m_ovf = m_ovf | ((m_acc[31] == d[31]) && (t[31] != m_acc[31]));
    m_co  = m_co | t[32];
`ifdef ACC32_SAT_EN
    m_acc = t[32] ? 32'hFFFF_FFFF : t[31:0];
`else
    m_acc = t[31:0];
`endif
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (in_ready !== 1'b1) begin
      $display("FAIL beat_ready: in_ready=%b want 1", in_ready);
      miscompares++;
    end
    vectors++;
    model_add(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last) begin
      sb_q.push_back('{sum: m_acc, cnt: m_cnt, co: m_co, ovf: m_ovf});
      model_zero();
    end
  endtask

  task automatic collect(input string name);
    int   n;
    res_t exp_r;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      $display("FAIL %s_timeout: out_valid=%b want 1", name, out_valid);
      miscompares++;
    end else if (sb_q.size() == 0) begin
      $display("FAIL %s_unexpected: result %h with empty queue",
               name, actual());
      miscompares++;
    end else begin
      exp_r = sb_q.pop_front();
      if (actual() !== exp_r) begin
        $display("FAIL %s_result: got %h want %h", name, actual(), exp_r);
        miscompares++;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL %s_release: in_ready=%b out_valid=%b want 1/0",
               name, in_ready, out_valid);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd5;
    in_last   = 1'b1;
    out_ready = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
      miscompares++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (actual() !== res_t'(0) || out_valid !== 1'b0) begin
      $display("FAIL reset_state: got %h valid %b want 0 valid 0",
               actual(), out_valid);
      miscompares++;
    end
    send_beat(32'd3, 1'b0);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_zero();
    @(posedge clk);
    #1;
    vectors++;
    if (actual() !== res_t'(0) || out_valid !== 1'b0) begin
      $display("FAIL reset_midgroup: got %h valid %b want 0 valid 0",
               actual(), out_valid);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b0);
    send_beat(32'd30, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL basic_latency: valid=%b ready=%b want 1/0",
               out_valid, in_ready);
      miscompares++;
    end
    vectors++;
    if (out_sum !== 32'd60 || out_cnt !== 8'd3) begin
      $display("FAIL basic_const: sum=%0d cnt=%0d want 60/3",
               out_sum, out_cnt);
      miscompares++;
    end
    collect("basic");
  endtask

  task automatic test_carry();
    send_beat(32'hFFFF_FFF0, 1'b0);
    send_beat(32'h0000_0020, 1'b1);
    vectors++;
`ifdef ACC32_SAT_EN
    if (out_sum !== 32'hFFFF_FFFF || out_co !== 1'b1) begin
      $display("FAIL carry_sat: sum=%h co=%b want ffffffff/1",
               out_sum, out_co);
      miscompares++;
    end
`else
    if (out_sum !== 32'h10 || out_co !== 1'b1) begin
      $display("FAIL carry_wrap: sum=%h co=%b want 00000010/1",
               out_sum, out_co);
      miscompares++;
    end
`endif
    collect("carry");
  endtask

  task automatic test_ovf();
    send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'h0000_0001, 1'b1);
    vectors++;
    if (out_sum !== 32'h8000_0000 || out_ovf !== 1'b1 ||
        out_co !== 1'b0) begin
      $display("FAIL ovf_const: sum=%h ovf=%b co=%b want 80000000/1/0",
               out_sum, out_ovf, out_co);
      miscompares++;
    end
    collect("ovf");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      send_beat(d, i == 5);
    end
    collect("b2b");
  endtask

  task automatic test_backpressure();
    res_t held;
    send_beat(32'd5, 1'b0);
    send_beat(32'd6, 1'b1);
    held = sb_q[0];
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          actual() !== held) begin
        $display("FAIL hold_%0d: ready=%b valid=%b out=%h want 0/1/%h",
                 i, in_ready, out_valid, actual(), held);
        miscompares++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("hold");
    send_beat(32'd7, 1'b1);
    vectors++;
    if (out_sum !== 32'd7 || out_cnt !== 8'd1) begin
      $display("FAIL hold_next: sum=%0d cnt=%0d want 7/1",
               out_sum, out_cnt);
      miscompares++;
    end
    collect("hold_next");
  endtask

  task automatic test_clear();
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd99;
    in_last  = 1'b0;
    clear    = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      $display("FAIL clear_ready: got %b want 1", in_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_zero();
    vectors++;
    if (actual() !== res_t'(0) || out_valid !== 1'b0) begin
      $display("FAIL clear_state: got %h valid %b want 0 valid 0",
               actual(), out_valid);
      miscompares++;
    end
    send_beat(32'd4, 1'b1);
    vectors++;
    if (out_sum !== 32'd4 || out_cnt !== 8'd1) begin
      $display("FAIL clear_next: sum=%0d cnt=%0d want 4/1",
               out_sum, out_cnt);
      miscompares++;
    end
    collect("clear_next");
  endtask

  task automatic test_cnt_sat();
    for (int i = 0; i < 260; i++) begin
      send_beat(32'd1, i == 259);
    end
    vectors++;
    if (out_cnt !== 8'hFF) begin
      $display("FAIL cnt_sat: cnt=%0d want 255", out_cnt);
      miscompares++;
    end
    collect("cnt_sat");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_carry();
    test_ovf();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_cnt_sat();
    vectors++;
    if (sb_q.size() != 0) begin
      $display("FAIL sb_drain: %0d left want 0", sb_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
